fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction-fetch stage that directly feeds the IF/ID pipeline register. It owns the program counter and issues one instruction-memory request at a time over a req/gnt/rvalid handshake. It delivers each fetched {PC, instruction} pair to IF/ID with a one-cycle load strobe. It honours stalls from the hazard unit and PC redirects from branch/jump resolution, and discards responses made stale by a redirect.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
PC_STEP, 4, sequential PC increment in bytes.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
stall_if  input  1  1 = IF/ID cannot accept a new instruction this cycle
redirect_valid  input  1  1 = take redirect_pc as next fetch PC
redirect_pc  input  32  branch/jump target
imem_req  output  1  fetch request
imem_addr  output  32  fetch address, word aligned
imem_gnt  input  1  memory accepted request this cycle
imem_rvalid  input  1  read data valid
imem_rdata  input  32  instruction word
out_PC  output  32  PC of delivered instruction, to IF/ID in_PC
out_IM  output  32  delivered instruction, to IF/ID in_IM
out_valid  output  1  one-cycle strobe, to IF/ID load

Behaviour:
- Reset (reset==0, asynchronous): pc=RESET_PC; state=REQ; out_PC=0; out_IM=0; out_valid=0; hold buffer cleared.
- imem_req=1 only in REQ; it is forced to 0 while reset==0. imem_addr is always {pc[31:2],2'b00}.
- At most one outstanding request. Responses arrive ≥1 cycle after grant, in order.
- out_valid, out_PC and out_IM are registered. out_valid is high for exactly one cycle per delivered instruction. out_PC and out_IM hold their last value otherwise.
- REQ state:
  - imem_gnt=1 → WAIT.
  - redirect_valid=1 → pc=redirect_pc&~3.
  - gnt and redirect in the same cycle → DISCARD.
- WAIT state:
  - imem_rvalid=1 and stall_if=0 → out_PC=pc, out_IM=imem_rdata, out_valid=1, pc=pc+PC_STEP, go to REQ.
  - imem_rvalid=1 and stall_if=1 → buffer {pc, rdata}, go to HOLD.
  - redirect_valid=1 without rvalid → pc=redirect_pc, go to DISCARD.
  - redirect_valid=1 with rvalid in the same cycle → data dropped, pc=redirect_pc, go to REQ.
- DISCARD state: wait for imem_rvalid, drop the data without a strobe, go to REQ. A further redirect here only updates pc.
- HOLD state:
  - stall_if=0 → deliver buffered pair with out_valid=1, pc=pc+PC_STEP, go to REQ.
  - redirect_valid=1 → buffer dropped, pc=redirect_pc, go to REQ, no strobe.
- Priority within any state: reset > redirect_valid > stall_if > normal progress.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- Best-case throughput is one instruction per 2 cycles (gnt in REQ, rvalid in the next cycle). Latency from rvalid to out_valid is 1 cycle.
- Reset mid-transaction: all state is cleared immediately. The memory side must likewise be reset; no late response is expected after reset.
- State encoding is free; an unreachable state must recover to REQ.

Test Plan:
- Reset then release with memory giving gnt immediately and rvalid 1 cycle later (rdata = 0x00500093, 0x00100113, …) → out_valid pulses every 2 cycles; out_PC = 0, 4, 8; out_IM matches the rdata sequence.
- stall_if=1 for 3 cycles spanning rvalid of PC 8 → no strobe while stalled, no new imem_req; on release, out_PC=8 delivered once, then fetch of 12 issues.
- redirect_valid=1, redirect_pc=0x100 while in WAIT for PC 4 → PC 4 response dropped with no strobe; next imem_addr=0x100; next out_PC=0x100.
- Redirect coincident with imem_rvalid, and coincident with imem_gnt → no strobe for the old PC; only target 0x200 is delivered. Also check redirect_pc=0x203 yields imem_addr=0x200.
- RESET_PC=32'hFFFF_FFFC → first out_PC=0xFFFFFFFC, second out_PC=0x00000000.
- reset pulled low while in WAIT and while out_valid=1 → same-cycle asynchronous clear: out_valid=0, imem_req=0, out_PC=0. After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage feeding the IF/ID pipeline register. Owns the
// program counter, issues one instruction-memory request at a time over a
// req/gnt/rvalid handshake and hands each fetched {PC, instruction} pair to
// IF/ID with a one-cycle load strobe. Honours stalls from the hazard unit,
// takes PC redirects from branch/jump resolution and throws away responses
// that a redirect has made stale.
//
// Parameters
//   RESET_PC       PC loaded on reset (word aligned)
//   PC_STEP        sequential PC increment in bytes
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous active-low reset
//   stall_if       IF/ID cannot accept an instruction this cycle
//   redirect_valid take redirect_pc as the next fetch PC
//   redirect_pc    branch/jump target (low two bits ignored)
//   imem_req       fetch request (only while idle and out of reset)
//   imem_addr      word-aligned fetch address
//   imem_gnt       memory accepted the request this cycle
//   imem_rvalid    read data valid
//   imem_rdata     instruction word
//   out_PC         PC of the delivered instruction
//   out_IM         delivered instruction
//   out_valid      one-cycle load strobe for IF/ID
// -----------------------------------------------------------------------------
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned PC_STEP  = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall_if,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] out_PC,
   output logic [31:0] out_IM,
   output logic        out_valid
);

   localparam logic [31:0] PC_INC = 32'(PC_STEP);

   // REQ     : request may be issued this cycle
   // WAIT    : request granted, response still owed and still wanted
   // DISCARD : response still owed but made stale by a redirect
   // HOLD    : response captured while IF/ID was stalled
   typedef enum logic [1:0] {
      ST_REQ     = 2'd0,
      ST_WAIT    = 2'd1,
      ST_DISCARD = 2'd2,
      ST_HOLD    = 2'd3
   } state_t;

   // Clears the byte-offset bits so every fetch address is word aligned.
   function automatic logic [31:0] f_word_align(input logic [31:0] addr);
      f_word_align = addr & 32'hFFFF_FFFC;
   endfunction

   // Sequential successor; wraps modulo 2^32 through the fixed 32-bit width.
   function automatic logic [31:0] f_seq_pc(input logic [31:0] pc);
      f_seq_pc = pc + PC_INC;
   endfunction

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_hold_pc;
   logic [31:0] r_hold_im;
   logic [31:0] r_out_pc;
   logic [31:0] r_out_im;
   logic        r_out_valid;

   logic [31:0] w_redirect_pc;

   assign w_redirect_pc = f_word_align(redirect_pc);

   // The request is a decode of the state register; gating with reset keeps
   // it low for the whole time reset is held, not just until the first edge.
   assign imem_req  = reset & (r_state == ST_REQ);
   assign imem_addr = f_word_align(r_pc);

   assign out_PC    = r_out_pc;
   assign out_IM    = r_out_im;
   assign out_valid = r_out_valid;

   // Fetch control FSM together with PC, hold buffer and IF/ID output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= ST_REQ;
         r_pc        <= f_word_align(RESET_PC);
         r_hold_pc   <= 32'h0000_0000;
         r_hold_im   <= 32'h0000_0000;
         r_out_pc    <= 32'h0000_0000;
         r_out_im    <= 32'h0000_0000;
         r_out_valid <= 1'b0;
      end else begin
         // Strobe is a single-cycle pulse; the data registers keep their value.
         r_out_valid <= 1'b0;

         case (r_state)
            ST_REQ: begin
               if (redirect_valid) begin
                  r_pc <= w_redirect_pc;
                  // A grant taken alongside a redirect fetched the old PC.
                  if (imem_gnt) begin
                     r_state <= ST_DISCARD;
                  end else begin
                     r_state <= ST_REQ;
                  end
               end else if (imem_gnt) begin
                  r_state <= ST_WAIT;
               end else begin
                  r_state <= ST_REQ;
               end
            end

            ST_WAIT: begin
               if (redirect_valid) begin
                  r_pc <= w_redirect_pc;
                  // Response arriving now is simply dropped; otherwise it is
                  // still owed and must be absorbed in DISCARD.
                  if (imem_rvalid) begin
                     r_state <= ST_REQ;
                  end else begin
                     r_state <= ST_DISCARD;
                  end
               end else if (imem_rvalid) begin
                  if (stall_if) begin
                     r_hold_pc <= r_pc;
                     r_hold_im <= imem_rdata;
                     r_state   <= ST_HOLD;
                  end else begin
                     r_out_pc    <= r_pc;
                     r_out_im    <= imem_rdata;
                     r_out_valid <= 1'b1;
                     r_pc        <= f_seq_pc(r_pc);
                     r_state     <= ST_REQ;
                  end
               end else begin
                  r_state <= ST_WAIT;
               end
            end

            ST_DISCARD: begin
               if (redirect_valid) begin
                  r_pc <= w_redirect_pc;
               end else begin
                  r_pc <= r_pc;
               end
               if (imem_rvalid) begin
                  r_state <= ST_REQ;
               end else begin
                  r_state <= ST_DISCARD;
               end
            end

            ST_HOLD: begin
               if (redirect_valid) begin
                  r_hold_pc <= 32'h0000_0000;
                  r_hold_im <= 32'h0000_0000;
                  r_pc      <= w_redirect_pc;
                  r_state   <= ST_REQ;
               end else if (!stall_if) begin
                  r_out_pc    <= r_hold_pc;
                  r_out_im    <= r_hold_im;
                  r_out_valid <= 1'b1;
                  r_pc        <= f_seq_pc(r_hold_pc);
                  r_state     <= ST_REQ;
               end else begin
                  r_state <= ST_HOLD;
               end
            end

            default: begin
               r_state <= ST_REQ;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//
// Directed bench for fetch_stage. A transaction-level model tracks which
// granted request is outstanding, whether a redirect has made it stale, what
// is parked behind a stall and which PC must be fetched next; a compare
// process checks every DUT output against it once per cycle. Literal checks
// on the observed delivery log pin the model to hand-computed values. A second
// instance with RESET_PC = 32'hFFFF_FFFC covers PC wrap-around.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall_if;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] out_PC;
   logic [31:0] out_IM;
   logic        out_valid;

   logic        req2;
   logic [31:0] addr2;
   logic        gnt2;
   logic        rvalid2;
   logic [31:0] rdata2;
   logic [31:0] out_pc2;
   logic [31:0] out_im2;
   logic        out_valid2;

   int n_checks = 0;
   int n_fail   = 0;

   // Model state
   logic        m_out_valid;
   logic [31:0] m_out_pc;
   logic [31:0] m_out_im;
   logic        m_outstanding;
   logic [31:0] m_out_addr;
   logic        m_stale;
   logic        m_hold;
   logic [31:0] m_hold_pc;
   logic [31:0] m_hold_im;
   logic [31:0] m_next;

   // Memory responder state
   logic        mem_busy;
   logic [31:0] mem_addr;
   int          mem_wait;
   int          mem_lat = 1;

   logic        busy2;
   logic [31:0] rsp_addr2;

   logic [31:0] dv_pc[$];
   logic [31:0] dv_im[$];
   logic [31:0] q2_pc[$];
   logic [31:0] q2_im[$];

   fetch_stage #(.RESET_PC(32'h0000_0000), .PC_STEP(4)) dut (
      .clk(clk), .reset(reset), .stall_if(stall_if),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .out_PC(out_PC), .out_IM(out_IM), .out_valid(out_valid)
   );

   fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .PC_STEP(4)) dut_wrap (
      .clk(clk), .reset(reset), .stall_if(1'b0),
      .redirect_valid(1'b0), .redirect_pc(32'h0000_0000),
      .imem_req(req2), .imem_addr(addr2), .imem_gnt(gnt2),
      .imem_rvalid(rvalid2), .imem_rdata(rdata2),
      .out_PC(out_pc2), .out_IM(out_im2), .out_valid(out_valid2)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0000_0000: mem_word = 32'h0050_0093;
         32'h0000_0004: mem_word = 32'h0010_0113;
         32'h0000_0008: mem_word = 32'h0020_0193;
         default:       mem_word = 32'h1300_0000 ^ a;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_out_valid   = 1'b0;
      m_out_pc      = 32'h0;
      m_out_im      = 32'h0;
      m_outstanding = 1'b0;
      m_out_addr    = 32'h0;
      m_stale       = 1'b0;
      m_hold        = 1'b0;
      m_hold_pc     = 32'h0;
      m_hold_im     = 32'h0;
      m_next        = 32'h0000_0000;
      mem_busy      = 1'b0;
      mem_addr      = 32'h0;
      mem_wait      = 0;
   endtask

   task automatic deliver(input logic [31:0] pc, input logic [31:0] im);
      m_out_valid = 1'b1;
      m_out_pc    = pc;
      m_out_im    = im;
      m_next      = pc + 32'd4;
   endtask

   // What must happen at the coming clock edge given these inputs.
   task automatic model_step(input logic st, input logic rd, input logic [31:0] rpc,
                             input logic g, input logic rv, input logic [31:0] rdat);
      logic req_now;
      logic got_rsp;
      req_now = !m_outstanding && !m_hold;
      got_rsp = m_outstanding && rv;
      m_out_valid = 1'b0;
      if (m_hold) begin
         if (rd) m_hold = 1'b0;
         else if (!st) begin
            deliver(m_hold_pc, m_hold_im);
            m_hold = 1'b0;
         end
      end
      if (got_rsp) begin
         m_outstanding = 1'b0;
         if (!m_stale && !rd) begin
            if (st) begin
               m_hold    = 1'b1;
               m_hold_pc = m_out_addr;
               m_hold_im = rdat;
            end else begin
               deliver(m_out_addr, rdat);
            end
         end
      end else if (req_now && g) begin
         m_outstanding = 1'b1;
         m_out_addr    = m_next;
         m_stale       = rd;
      end else if (m_outstanding && rd) begin
         m_stale = 1'b1;
      end
      if (rd) m_next = rpc & 32'hFFFF_FFFC;
   endtask

   // One clock cycle of stimulus, driven on the falling edge.
   task automatic step(input logic st, input logic rd, input logic [31:0] rpc);
      logic        g;
      logic        rv;
      logic [31:0] rdat;
      @(negedge clk);
      g    = imem_req && !mem_busy;
      rv   = mem_busy && (mem_wait == 0);
      rdat = rv ? mem_word(mem_addr) : 32'hDEAD_BEEF;
      stall_if       = st;
      redirect_valid = rd;
      redirect_pc    = rpc;
      imem_gnt       = g;
      imem_rvalid    = rv;
      imem_rdata     = rdat;
      if (reset) model_step(st, rd, rpc, g, rv, rdat);
      if (rv) mem_busy = 1'b0;
      else if (mem_busy) mem_wait--;
      if (g) begin
         mem_busy = 1'b1;
         mem_addr = imem_addr;
         mem_wait = mem_lat - 1;
      end
   endtask

   task automatic release_reset();
      @(negedge clk);
      reset          = 1'b1;
      stall_if       = 1'b0;
      redirect_valid = 1'b0;
      imem_gnt       = 1'b0;
      imem_rvalid    = 1'b0;
   endtask

   // Asynchronous assertion in the middle of a cycle; checks the same-cycle clear.
   task automatic async_reset(input string tag);
      @(posedge clk);
      #3;
      reset = 1'b0;
      model_reset();
      #1;
      chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
      chk({tag, "_imem_req"},  {31'd0, imem_req},  32'd0);
      chk({tag, "_out_PC"},    out_PC,             32'h0);
      chk({tag, "_out_IM"},    out_IM,             32'h0);
   endtask

   // Per-cycle comparison against the model.
   initial begin
      logic exp_req;
      forever begin
         @(posedge clk);
         #1;
         exp_req = reset && !m_outstanding && !m_hold;
         chk("out_valid", {31'd0, out_valid}, {31'd0, m_out_valid});
         chk("out_PC",    out_PC,             m_out_pc);
         chk("out_IM",    out_IM,             m_out_im);
         chk("imem_req",  {31'd0, imem_req},  {31'd0, exp_req});
         if (exp_req) chk("imem_addr", imem_addr, m_next);
         if (out_valid) begin
            dv_pc.push_back(out_PC);
            dv_im.push_back(out_IM);
         end
      end
   end

   // Always-grant memory for the wrap-around instance, response one cycle later.
   initial begin
      busy2 = 1'b0; gnt2 = 1'b0; rvalid2 = 1'b0; rdata2 = 32'h0; rsp_addr2 = 32'h0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            busy2 = 1'b0; gnt2 = 1'b0; rvalid2 = 1'b0;
         end else begin
            rvalid2 = busy2;
            rdata2  = busy2 ? (32'hCAFE_0000 ^ rsp_addr2) : 32'h0;
            gnt2    = req2 && !busy2;
            if (busy2) busy2 = 1'b0;
            else if (gnt2) begin
               busy2     = 1'b1;
               rsp_addr2 = addr2;
            end
         end
      end
   end

   // Delivery log of the wrap-around instance.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (out_valid2) begin
            q2_pc.push_back(out_pc2);
            q2_im.push_back(out_im2);
         end
      end
   end

   initial begin
      int n8;
      int n16;
      int n204;
      reset = 1'b0; stall_if = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
      imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
      model_reset();
      repeat (2) step(1'b0, 1'b0, 32'h0);
      release_reset();

      // Back-to-back fetch, then 3-cycle stall spanning the PC 8 response.
      repeat (5) step(1'b0, 1'b0, 32'h0);
      repeat (3) step(1'b1, 1'b0, 32'h0);
      @(posedge clk); #2;
      chk("stall_no_req",    {31'd0, imem_req},  32'd0);
      chk("stall_no_strobe", {31'd0, out_valid}, 32'd0);
      repeat (3) step(1'b0, 1'b0, 32'h0);
      @(posedge clk); #2;
      chk("seq_count", dv_pc.size(), 32'd4);
      if (dv_pc.size() >= 4) begin
         chk("seq_pc0", dv_pc[0], 32'h0000_0000);
         chk("seq_im0", dv_im[0], 32'h0050_0093);
         chk("seq_pc1", dv_pc[1], 32'h0000_0004);
         chk("seq_im1", dv_im[1], 32'h0010_0113);
         chk("seq_pc2", dv_pc[2], 32'h0000_0008);
         chk("seq_im2", dv_im[2], 32'h0020_0193);
         chk("seq_pc3", dv_pc[3], 32'h0000_000C);
      end
      n8 = 0;
      foreach (dv_pc[i]) if (dv_pc[i] == 32'h8) n8++;
      chk("pc8_once", n8, 32'd1);

      // Redirect while waiting on a slow response (PC 16).
      mem_lat = 3;
      step(1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b1, 32'h0000_0100);
      step(1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 32'h0);
      mem_lat = 1;
      @(posedge clk); #2;
      chk("redir_addr", imem_addr, 32'h0000_0100);
      step(1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 32'h0);
      @(posedge clk); #2;
      chk("redir_last_pc", dv_pc[$], 32'h0000_0100);
      n16 = 0;
      foreach (dv_pc[i]) if (dv_pc[i] == 32'h10) n16++;
      chk("pc16_dropped", n16, 32'd0);

      // Redirect coincident with rvalid (fetch of 0x104).
      step(1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b1, 32'h0000_0200);
      step(1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 32'h0);
      // Redirect coincident with gnt (fetch of 0x204), unaligned target.
      step(1'b0, 1'b1, 32'h0000_0203);
      step(1'b0, 1'b0, 32'h0);
      @(posedge clk); #2;
      chk("unaligned_addr", imem_addr, 32'h0000_0200);
      step(1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 32'h0);
      @(posedge clk); #2;
      chk("coinc_count", dv_pc.size(), 32'd7);
      chk("coinc_pc_a", dv_pc[dv_pc.size()-2], 32'h0000_0200);
      chk("coinc_pc_b", dv_pc[$], 32'h0000_0200);
      chk("coinc_im_b", dv_im[$], 32'h1300_0200);

      // Redirect while holding a stalled response.
      step(1'b0, 1'b0, 32'h0);
      step(1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b1, 32'h0000_0300);
      step(1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 32'h0);
      @(posedge clk); #2;
      chk("hold_redir_pc", dv_pc[$], 32'h0000_0300);
      chk("hold_redir_im", dv_im[$], 32'h1300_0300);
      n204 = 0;
      foreach (dv_pc[i]) if (dv_pc[i] == 32'h204) n204++;
      chk("pc204_dropped", n204, 32'd0);

      // Reset while in WAIT.
      step(1'b0, 1'b0, 32'h0);
      async_reset("rst_wait");
      repeat (2) step(1'b0, 1'b0, 32'h0);
      release_reset();
      step(1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 32'h0);
      // Reset while the strobe is high.
      @(posedge clk); #2;
      chk("pre_rst_strobe", {31'd0, out_valid}, 32'd1);
      chk("restart_pc", out_PC, 32'h0000_0000);
      chk("restart_im", out_IM, 32'h0050_0093);
      #1;
      reset = 1'b0;
      model_reset();
      #1;
      chk("rst_strobe_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_strobe_imem_req",  {31'd0, imem_req},  32'd0);
      chk("rst_strobe_out_PC",    out_PC,             32'h0);
      repeat (2) step(1'b0, 1'b0, 32'h0);
      release_reset();
      repeat (4) step(1'b0, 1'b0, 32'h0);
      @(posedge clk); #2;
      chk("restart2_pc", dv_pc[dv_pc.size()-2], 32'h0000_0000);
      chk("restart2_next", dv_pc[$], 32'h0000_0004);

      // Wrap-around instance.
      chk("wrap_count_ok", {31'd0, q2_pc.size() >= 2}, 32'd1);
      if (q2_pc.size() >= 2) begin
         chk("wrap_pc0", q2_pc[0], 32'hFFFF_FFFC);
         chk("wrap_im0", q2_im[0], 32'h3501_FFFC);
         chk("wrap_pc1", q2_pc[1], 32'h0000_0000);
         chk("wrap_im1", q2_im[1], 32'hCAFE_0000);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
